// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising receive checker for the byte-wide PRBS15 (x^15+x^14+1) stream.
// Define PRBS_CHK_ERR_CNT_EN to build the saturating bit-error counter; otherwise err_cnt is 0.
module prbs_checker #(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 4,
  parameter int CNT_W    = 32
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             in_valid,
  input  logic [7:0]       in,
  input  logic             clear,
  output logic             locked,
  output logic             lock_lost,
  output logic             byte_err,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [1:0] HUNT   = 2'd0;
  localparam logic [1:0] VERIFY = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  localparam int MATCH_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
  localparam int MISS_W  = (LOSS_CNT > 1) ? $clog2(LOSS_CNT) : 1;
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
  localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(LOSS_CNT - 1);

  // Returns {state after 8 steps, predicted byte} with the first generated bit in bit 7.
  function automatic logic [22:0] prbs_step8(input logic [14:0] s);
    logic [14:0] st;
    logic [7:0]  p;
    logic        b;
    st = s;
    p  = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      b    = st[14] ^ st[13];
      p[i] = b;
      st   = {st[13:0], b};
    end
    return {st, p};
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'd0, v[i]};
    end
    return n;
  endfunction

  logic [1:0]         state_r;
  logic [14:0]        s_r;
  logic               hunt_cnt_r;
  logic [MATCH_W-1:0] match_cnt_r;
  logic [MISS_W-1:0]  miss_cnt_r;

  logic [14:0] s_adv_s;
  logic [7:0]  pred_s;
  logic [3:0]  e_s;

  assign {s_adv_s, pred_s} = prbs_step8(s_r);
  assign e_s = popcount8(in ^ pred_s);

  // Sync state machine, LFSR state and the lock/error pulse outputs.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_r     <= HUNT;
      s_r         <= 15'h0000;
      hunt_cnt_r  <= 1'b0;
      match_cnt_r <= '0;
      miss_cnt_r  <= '0;
      locked      <= 1'b0;
      lock_lost   <= 1'b0;
      byte_err    <= 1'b0;
    end else begin
      lock_lost <= 1'b0;
      byte_err  <= 1'b0;
      if (in_valid) begin
        case (state_r)
          HUNT: begin
            s_r <= {s_r[6:0], in};
            if (hunt_cnt_r == 1'b1) begin
              state_r     <= VERIFY;
              hunt_cnt_r  <= 1'b0;
              match_cnt_r <= '0;
            end else begin
              hunt_cnt_r <= 1'b1;
            end
          end
          VERIFY: begin
            // An all-zero seed predicts zeros forever, so it is rejected even when it matches.
            if ((in == pred_s) && (s_r != 15'h0000)) begin
              s_r <= s_adv_s;
              if (match_cnt_r == MATCH_LAST) begin
                state_r    <= LOCKED;
                locked     <= 1'b1;
                miss_cnt_r <= '0;
              end else begin
                match_cnt_r <= match_cnt_r + MATCH_W'(1);
              end
            end else begin
              state_r    <= HUNT;
              s_r        <= {s_r[6:0], in};
              hunt_cnt_r <= 1'b1;
            end
          end
          LOCKED: begin
            if (e_s == 4'd0) begin
              s_r        <= s_adv_s;
              miss_cnt_r <= '0;
            end else begin
              byte_err <= 1'b1;
              if (miss_cnt_r == MISS_LAST) begin
                state_r    <= HUNT;
                hunt_cnt_r <= 1'b0;
                miss_cnt_r <= '0;
                locked     <= 1'b0;
                lock_lost  <= 1'b1;
              end else begin
                s_r        <= s_adv_s;
                miss_cnt_r <= miss_cnt_r + MISS_W'(1);
              end
            end
          end
          default: begin
            state_r <= HUNT;
            locked  <= 1'b0;
          end
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

`ifdef PRBS_CHK_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt_r;
  logic [CNT_W:0]   sum_s;

  assign sum_s = {1'b0, err_cnt_r} + (CNT_W+1)'(e_s);

  // Saturating bit-error accumulator; clear takes priority over the byte being counted.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      err_cnt_r <= '0;
    end else if (clear) begin
      err_cnt_r <= '0;
    end else if (in_valid && (state_r == LOCKED) && (e_s != 4'd0)) begin
      err_cnt_r <= sum_s[CNT_W] ? '1 : sum_s[CNT_W-1:0];
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  assign err_cnt = err_cnt_r;
`else
  logic unused_clear_s;
  assign unused_clear_s = clear;
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// Self-checking bench for prbs_checker: directed scenarios plus a randomized stream,
// all compared against a bit-history reference model; a CNT_W=4 copy covers saturation.
module tb_prbs_checker;

  localparam int LOCK_CNT = 4;
  localparam int LOSS_CNT = 4;
`ifdef PRBS_CHK_ERR_CNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam int H = 0, V = 1, L = 2;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  din = 8'h00;
  logic        clear = 1'b0;
  logic        locked, lock_lost, byte_err;
  logic [31:0] err_cnt;
  logic        locked4, lock_lost4, byte_err4;
  logic [3:0]  err_cnt4;

  int n_tests = 0;
  int n_fail  = 0;

  prbs_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .CNT_W(32)) dut (
    .CLK(CLK), .RSTn(RSTn), .in_valid(in_valid), .in(din), .clear(clear),
    .locked(locked), .lock_lost(lock_lost), .byte_err(byte_err), .err_cnt(err_cnt));

  prbs_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .CNT_W(4)) dut4 (
    .CLK(CLK), .RSTn(RSTn), .in_valid(in_valid), .in(din), .clear(clear),
    .locked(locked4), .lock_lost(lock_lost4), .byte_err(byte_err4), .err_cnt(err_cnt4));

  always #5 CLK = ~CLK;

  // ---------------- reference model: last 15 bits of the sequence as a bit queue
  int     m_state, m_hunt, m_match, m_miss;
  bit     m_hist[$];
  longint m_err32, m_err4;
  bit     m_locked, m_lost, m_berr;

  task automatic model_reset();
    m_state = H; m_hunt = 0; m_match = 0; m_miss = 0;
    m_hist = {};
    for (int i = 0; i < 15; i++) m_hist.push_back(1'b0);
    m_err32 = 0; m_err4 = 0; m_locked = 0; m_lost = 0; m_berr = 0;
  endtask

  task automatic model_push(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      m_hist.push_back(b[i]);
      void'(m_hist.pop_front());
    end
  endtask

  // Each new bit is bit(n-15) xor bit(n-14) of the sequence.
  function automatic logic [7:0] model_predict();
    bit q[$];
    bit nb;
    logic [7:0] p;
    q = m_hist;
    p = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      nb = q[0] ^ q[1];
      p[i] = nb;
      q.push_back(nb);
      void'(q.pop_front());
    end
    return p;
  endfunction

  function automatic bit model_nonzero();
    bit any;
    any = 1'b0;
    foreach (m_hist[i]) any |= m_hist[i];
    return any;
  endfunction

  task automatic model_step(input logic v, input logic [7:0] b, input logic clr);
    logic [7:0] p;
    int e;
    p = model_predict();
    e = $countones(b ^ p);
    m_lost = 0; m_berr = 0;
    if (clr) begin m_err32 = 0; m_err4 = 0; end
    if (v) begin
      if (m_state == H) begin
        model_push(b); m_hunt++;
        if (m_hunt == 2) begin m_state = V; m_hunt = 0; m_match = 0; end
      end else if (m_state == V) begin
        if (b == p && model_nonzero()) begin
          model_push(p); m_match++;
          if (m_match == LOCK_CNT) begin m_state = L; m_miss = 0; end
        end else begin
          m_state = H; model_push(b); m_hunt = 1;
        end
      end else begin
        if (e == 0) begin
          model_push(p); m_miss = 0;
        end else begin
          m_berr = 1;
          if (!clr) begin
            m_err32 = (m_err32 + e > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_err32 + e;
            m_err4  = (m_err4 + e > 15) ? 15 : m_err4 + e;
          end
          m_miss++;
          if (m_miss == LOSS_CNT) begin m_state = H; m_hunt = 0; m_miss = 0; m_lost = 1; end
          else model_push(p);
        end
      end
    end
    m_locked = (m_state == L);
  endtask

  function automatic logic [31:0] exp_e32();
    return ERR_EN ? m_err32[31:0] : 32'd0;
  endfunction

  function automatic logic [3:0] exp_e4();
    return ERR_EN ? m_err4[3:0] : 4'd0;
  endfunction

  // ---------------- stimulus
  logic [14:0] g;

  task automatic gen_next(output logic [7:0] b);
    logic nb;
    for (int i = 7; i >= 0; i--) begin
      nb = g[14] ^ g[13];
      b[i] = nb;
      g = {g[13:0], nb};
    end
  endtask

  task automatic send(input logic v, input logic [7:0] b, input logic clr);
    @(negedge CLK);
    in_valid = v; din = b; clear = clr;
    @(posedge CLK);
    #1;
    model_step(v, b, clr);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RSTn = 1'b0; in_valid = 1'b0; clear = 1'b0;
    @(negedge CLK);
    RSTn = 1'b1;
    model_reset();
  endtask

  // ---------------- scenarios
  task automatic test_reset();
    RSTn = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    model_reset();
    n_tests++;
    if ({locked, lock_lost, byte_err, locked4, lock_lost4, byte_err4} !== 6'b0 ||
        err_cnt !== 32'd0 || err_cnt4 !== 4'd0) begin
      n_fail++;
      $display("FAIL reset: locked=%b lost=%b berr=%b err=%0d err4=%0d, expected all 0",
               locked, lock_lost, byte_err, err_cnt, err_cnt4);
    end
    @(negedge CLK) RSTn = 1'b1;
  endtask

  task automatic test_lock();
    logic [7:0] b;
    do_reset();
    g = 15'h7FFF;
    for (int i = 0; i < 8; i++) begin
      gen_next(b);
      send(1'b1, b, 1'b0);
      n_tests++;
      if (locked !== (i >= 5) || locked !== m_locked || locked4 !== m_locked) begin
        n_fail++;
        $display("FAIL lock byte %0d: locked=%b locked4=%b expected %b", i + 1, locked, locked4, i >= 5);
      end
      n_tests++;
      if (byte_err !== 1'b0 || lock_lost !== 1'b0 || err_cnt !== 32'd0) begin
        n_fail++;
        $display("FAIL lock_clean byte %0d: berr=%b lost=%b err=%0d expected 0", i + 1, byte_err, lock_lost, err_cnt);
      end
    end
  endtask

  task automatic test_gaps();
    logic [7:0] b;
    logic v;
    do_reset();
    g = 15'h7FFF;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      v = cyc[0];
      if (v) gen_next(b);
      else b = 8'($urandom);
      send(v, b, 1'b0);
      n_tests++;
      if (locked !== (cyc >= 11) || locked !== m_locked) begin
        n_fail++;
        $display("FAIL gaps cycle %0d: locked=%b expected %b", cyc, locked, cyc >= 11);
      end
    end
  endtask

  task automatic test_errors();
    logic [7:0] b;
    logic [31:0] want;
    for (int i = 0; i < 10; i++) begin
      gen_next(b);
      if (i == 2) b = b ^ 8'h01;
      if (i == 6) b = ~b;
      send(1'b1, b, 1'b0);
      want = !ERR_EN ? 32'd0 : (i < 2) ? 32'd0 : (i < 6) ? 32'd1 : 32'd9;
      n_tests++;
      if (byte_err !== (i == 2 || i == 6) || byte_err4 !== m_berr || locked !== 1'b1) begin
        n_fail++;
        $display("FAIL errors byte %0d: berr=%b locked=%b expected berr=%b locked=1", i, byte_err, locked, i == 2 || i == 6);
      end
      n_tests++;
      if (err_cnt !== want || err_cnt !== exp_e32() || err_cnt4 !== want[3:0]) begin
        n_fail++;
        $display("FAIL errors_cnt byte %0d: err=%0d err4=%0d expected %0d", i, err_cnt, err_cnt4, want);
      end
    end
  endtask

  task automatic test_loss();
    logic [7:0] b;
    send(1'b0, 8'h00, 1'b1);
    n_tests++;
    if (err_cnt !== 32'd0 || err_cnt4 !== 4'd0) begin
      n_fail++;
      $display("FAIL loss_clear: err=%0d err4=%0d expected 0", err_cnt, err_cnt4);
    end
    for (int i = 0; i < 4; i++) begin
      gen_next(b);
      send(1'b1, ~b, 1'b0);
      n_tests++;
      if (lock_lost !== (i == 3) || locked !== (i < 3) || lock_lost4 !== m_lost) begin
        n_fail++;
        $display("FAIL loss byte %0d: lost=%b locked=%b expected lost=%b locked=%b", i, lock_lost, locked, i == 3, i < 3);
      end
    end
    n_tests++;
    if (err_cnt !== (ERR_EN ? 32'd32 : 32'd0) || err_cnt4 !== (ERR_EN ? 4'd15 : 4'd0)) begin
      n_fail++;
      $display("FAIL loss_cnt: err=%0d err4=%0d expected 32/15", err_cnt, err_cnt4);
    end
    for (int j = 0; j < 7; j++) begin
      gen_next(b);
      send(1'b1, b, 1'b0);
      n_tests++;
      if (locked !== (j >= 5) || lock_lost !== 1'b0 || locked !== m_locked) begin
        n_fail++;
        $display("FAIL relock byte %0d: locked=%b lost=%b expected locked=%b", j + 1, locked, lock_lost, j >= 5);
      end
    end
  endtask

  task automatic test_saturate();
    logic [7:0] b;
    logic [3:0] want4 [3];
    logic [31:0] want32 [3];
    want4  = '{4'd8, 4'd15, 4'd0};
    want32 = '{32'd8, 32'd16, 32'd0};
    send(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      gen_next(b);
      send(1'b1, ~b, i == 2);
      n_tests++;
      if (err_cnt4 !== (ERR_EN ? want4[i] : 4'd0) || err_cnt !== (ERR_EN ? want32[i] : 32'd0) ||
          err_cnt4 !== exp_e4()) begin
        n_fail++;
        $display("FAIL saturate step %0d: err4=%0d err=%0d expected %0d/%0d", i, err_cnt4, err_cnt, want4[i], want32[i]);
      end
      n_tests++;
      if (byte_err4 !== 1'b1 || locked4 !== 1'b1) begin
        n_fail++;
        $display("FAIL saturate_flags step %0d: berr4=%b locked4=%b expected 1/1", i, byte_err4, locked4);
      end
    end
    gen_next(b);
    send(1'b1, b, 1'b0);
  endtask

  task automatic test_zero();
    do_reset();
    for (int i = 0; i < 24; i++) begin
      send(1'b1, 8'h00, 1'b0);
      n_tests++;
      if (locked !== 1'b0 || locked4 !== 1'b0 || locked !== m_locked) begin
        n_fail++;
        $display("FAIL zero byte %0d: locked=%b locked4=%b expected 0", i, locked, locked4);
      end
    end
  endtask

  task automatic test_rst_midlock();
    logic [7:0] b;
    do_reset();
    g = 15'($urandom_range(1, 32767));
    for (int i = 0; i < 7; i++) begin
      gen_next(b);
      send(1'b1, (i == 6) ? (b ^ 8'h10) : b, 1'b0);
    end
    n_tests++;
    if (locked !== 1'b1 || err_cnt !== exp_e32() || byte_err !== 1'b1) begin
      n_fail++;
      $display("FAIL midlock_pre: locked=%b err=%0d berr=%b expected 1/%0d/1", locked, err_cnt, byte_err, exp_e32());
    end
    @(negedge CLK);
    in_valid = 1'b0;
    #2;
    RSTn = 1'b0;
    #1;
    n_tests++;
    if (locked !== 1'b0 || err_cnt !== 32'd0 || lock_lost !== 1'b0 || byte_err !== 1'b0) begin
      n_fail++;
      $display("FAIL midlock_async: locked=%b err=%0d lost=%b berr=%b expected 0", locked, err_cnt, lock_lost, byte_err);
    end
    @(posedge CLK);
    #1;
    n_tests++;
    if (lock_lost !== 1'b0 || lock_lost4 !== 1'b0 || locked4 !== 1'b0) begin
      n_fail++;
      $display("FAIL midlock_nolost: lost=%b lost4=%b locked4=%b expected 0", lock_lost, lock_lost4, locked4);
    end
    @(negedge CLK) RSTn = 1'b1;
    model_reset();
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic v, clr;
    int burst;
    do_reset();
    g = 15'($urandom_range(1, 32767));
    burst = 0;
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 40) == 0);
      b = 8'($urandom);
      if (v) begin
        if ($urandom_range(0, 150) == 0) gen_next(b);
        gen_next(b);
        if (burst > 0) begin
          b = ~b; burst--;
        end else if ($urandom_range(0, 80) == 0) begin
          burst = $urandom_range(2, 5);
        end else if ($urandom_range(0, 9) == 0) begin
          b = b ^ 8'($urandom_range(1, 255));
        end
      end
      send(v, b, clr);
      n_tests++;
      if (locked !== m_locked || lock_lost !== m_lost || byte_err !== m_berr || err_cnt !== exp_e32()) begin
        n_fail++;
        $display("FAIL random %0d: got locked=%b lost=%b berr=%b err=%0d expected %b %b %b %0d",
                 i, locked, lock_lost, byte_err, err_cnt, m_locked, m_lost, m_berr, exp_e32());
      end
      n_tests++;
      if (locked4 !== m_locked || lock_lost4 !== m_lost || byte_err4 !== m_berr || err_cnt4 !== exp_e4()) begin
        n_fail++;
        $display("FAIL random4 %0d: got locked=%b lost=%b berr=%b err=%0d expected %b %b %b %0d",
                 i, locked4, lock_lost4, byte_err4, err_cnt4, m_locked, m_lost, m_berr, exp_e4());
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_gaps();
    test_errors();
    test_loss();
    test_saturate();
    test_zero();
    test_rst_midlock();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
